noc_packetizer: RTL and testbench

//  Ingress stage in front of each NoC router input port. Accepts one wide module word plus

---
 rtl/noc_pkg.sv | 21 ++
 rtl/noc_word_fifo.sv | 45 ++++
 rtl/noc_packetizer.sv | 149 ++++++++++++++
 tb/tb_noc_packetizer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC constants: node count, default packetizer widths and the flit header layout.
// A flit is {head, tail, dest, payload}, with the header occupying the top bits.
package noc_pkg;
    localparam int NOC_NODES      = 16;
    localparam int NOC_DEST_W     = $clog2(NOC_NODES);
    localparam int DATA_WIDTH_DEF = 600;
    localparam int FLIT_WIDTH_DEF = 150;
    localparam int DEST_WIDTH_DEF = NOC_DEST_W;
    localparam int CREDITS_DEF    = 8;
    localparam int FIFO_DEPTH_DEF = 2;

    localparam int DEST_LSB = FLIT_WIDTH_DEF;
    localparam int TAIL_BIT = DEST_LSB + DEST_WIDTH_DEF;
    localparam int HEAD_BIT = TAIL_BIT + 1;

    typedef struct packed {
        logic                  head;
        logic                  tail;
        logic [NOC_DEST_W-1:0] dest;
    } flit_hdr_t;
endpackage

// File: rtl/noc_word_fifo.sv
// Word buffer for the packetizer: registered storage, read data shown combinationally from the head.
// Writes are refused when full and reads when empty, so the caller may gate loosely.
module noc_word_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    assign w_wr_en = i_push && !o_full;
    assign w_rd_en = i_pop && !o_empty;

    // Extra MSB on each pointer tells full from empty when the index bits match.
    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
    end
endmodule

// File: rtl/noc_packetizer.sv
// Buffers module words and serializes each into NUM_FLITS credit-gated flits; head flit one cycle after accept.
// Stalls (holding flit index) at zero credit; NOC_PKTZ_STATS_EN adds pkt_count/stall_count outputs.
module noc_packetizer
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int FLIT_WIDTH = FLIT_WIDTH_DEF,
    parameter int DEST_WIDTH = DEST_WIDTH_DEF,
    parameter int CREDITS    = CREDITS_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [DATA_WIDTH-1:0]          in_data,
    input  logic [DEST_WIDTH-1:0]          in_dest,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [FLIT_WIDTH+DEST_WIDTH+1:0] flit_out,
    output logic                           flit_valid,
    input  logic                           credit_in,
    output logic                           busy
`ifdef NOC_PKTZ_STATS_EN
    ,
    output logic [31:0]                    pkt_count,
    output logic [31:0]                    stall_count
`endif
);
    localparam int NUM_FLITS = DATA_WIDTH / FLIT_WIDTH;
    localparam int IDX_W     = (NUM_FLITS > 1) ? $clog2(NUM_FLITS) : 1;
    localparam int CNT_W     = $clog2(CREDITS + 1);
    localparam int FLIT_W    = FLIT_WIDTH + DEST_WIDTH + 2;
    localparam int HEAD_POS  = FLIT_W - 1;
    localparam int TAIL_POS  = FLIT_W - 2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_SEND = 1'b1;

    logic [0:0]                       r_state;
    logic [IDX_W-1:0]                 r_flit_idx;
    logic [CNT_W-1:0]                 r_credit_cnt;
    logic [FLIT_W-1:0]                r_flit;
    logic                             r_flit_vld;
    logic                             r_prev_tail;

    logic [DATA_WIDTH+DEST_WIDTH-1:0] w_fifo_dat;
    logic [DATA_WIDTH-1:0]            w_word;
    logic [DEST_WIDTH-1:0]            w_dest;
    logic [FLIT_WIDTH-1:0]            w_payload;
    logic                             w_full;
    logic                             w_empty;
    logic                             w_push;
    logic                             w_issue;
    logic                             w_last;
    logic                             w_pop;

    assign in_ready = rst && !w_full;
    assign w_push   = in_valid && in_ready;
    assign w_issue  = !w_empty && (r_credit_cnt != '0);
    assign w_last   = (r_flit_idx == IDX_W'(NUM_FLITS - 1));
    assign w_pop    = w_issue && w_last;
    assign w_word   = w_fifo_dat[DATA_WIDTH-1:0];
    assign w_dest   = w_fifo_dat[DATA_WIDTH+DEST_WIDTH-1:DATA_WIDTH];

    noc_word_fifo #(
        .WIDTH (DATA_WIDTH + DEST_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_word_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_dat   ({in_dest, in_data}),
        .i_pop   (w_pop),
        .o_dat   (w_fifo_dat),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Lowest slice goes out first.
    always_comb begin
        w_payload = '0;
        for (int k = 0; k < NUM_FLITS; k++) begin
            if (r_flit_idx == IDX_W'(k)) w_payload = w_word[k*FLIT_WIDTH +: FLIT_WIDTH];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_flit_idx <= '0;
            r_flit     <= '0;
            r_flit_vld <= 1'b0;
        end else begin
            r_flit_vld <= w_issue;
            if (w_issue) begin
                r_flit <= {(r_flit_idx == '0), w_last, w_dest, w_payload};
                if (w_last) begin
                    r_flit_idx <= '0;
                    r_state    <= S_IDLE;
                end else begin
                    r_flit_idx <= r_flit_idx + 1'b1;
                    r_state    <= S_SEND;
                end
            end
        end
    end

    // A credit returned in the same cycle as an issue cancels out; excess credits saturate.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_credit_cnt <= CNT_W'(CREDITS);
        end else begin
            case ({w_issue, credit_in})
                2'b10:   r_credit_cnt <= r_credit_cnt - 1'b1;
                2'b01:   if (r_credit_cnt != CNT_W'(CREDITS)) r_credit_cnt <= r_credit_cnt + 1'b1;
                default: r_credit_cnt <= r_credit_cnt;
            endcase
        end
    end

    assign flit_out   = r_flit;
    assign flit_valid = r_flit_vld;
    assign busy       = !w_empty || (r_state == S_SEND);

`ifdef NOC_PKTZ_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            pkt_count   <= '0;
            stall_count <= '0;
        end else begin
            if (w_pop) pkt_count <= pkt_count + 32'd1;
            if (!w_empty && (r_credit_cnt == '0)) stall_count <= stall_count + 32'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst)            r_prev_tail <= 1'b1;
        else if (r_flit_vld) r_prev_tail <= r_flit[TAIL_POS];
    end

    a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
        r_credit_cnt <= CNT_W'(CREDITS));
    a_issue_has_credit: assert property (@(posedge clk) disable iff (!rst)
        w_issue |-> (r_credit_cnt != '0));
    a_credit_overflow: assert property (@(posedge clk) disable iff (!rst)
        (credit_in && !w_issue) |-> (r_credit_cnt != CNT_W'(CREDITS)));
    a_head_after_tail: assert property (@(posedge clk) disable iff (!rst)
        r_flit_vld |-> (r_flit[HEAD_POS] == r_prev_tail));
endmodule

// File: tb/tb_noc_packetizer.sv
// Randomized bench for noc_packetizer against a queue-based model of accepted words and credits.
module tb_noc_packetizer;
    import noc_pkg::*;

    localparam int DW  = 600;
    localparam int FW  = 150;
    localparam int DSW = 4;
    localparam int CR  = 8;
    localparam int FD  = 2;
    localparam int NF  = DW / FW;
    localparam int FLW = FW + DSW + 2;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [DW-1:0]  in_data = '0;
    logic [DSW-1:0] in_dest = '0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [FLW-1:0] flit_out;
    logic           flit_valid;
    logic           credit_in = 1'b0;
    logic           busy;
`ifdef NOC_PKTZ_STATS_EN
    logic [31:0]    pkt_count;
    logic [31:0]    stall_count;
`endif

    always #5 clk = ~clk;

    noc_packetizer #(
        .DATA_WIDTH (DW), .FLIT_WIDTH (FW), .DEST_WIDTH (DSW), .CREDITS (CR), .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_dest    (in_dest),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flit_out   (flit_out),
        .flit_valid (flit_valid),
        .credit_in  (credit_in),
        .busy       (busy)
`ifdef NOC_PKTZ_STATS_EN
        ,
        .pkt_count  (pkt_count),
        .stall_count(stall_count)
`endif
    );

    typedef struct {
        logic [FLW-1:0] f;
        int             avail;
    } exp_t;

    exp_t           q[$];
    int             m_cnt = CR;
    int             m_words = 0;
    int             m_pkts = 0;
    int             m_stalls = 0;
    logic [FLW-1:0] m_last = '0;
    int             cyc = 0;
    int             n_iss = 0;
    int             words_left = 0;
    int             credit_mode = 0;   // 0 none, 1 whenever room, 2 random, 3 forced this tick
    int             n_checks = 0;
    int             n_pass = 0;

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [DW-1:0] rand_word();
        logic [607:0] t;
        for (int i = 0; i < 19; i++) t[i*32 +: 32] = $urandom;
        return t[DW-1:0];
    endfunction

    function automatic logic [FLW-1:0] mk_flit(input logic [DW-1:0] w, input logic [DSW-1:0] d,
                                                input int k);
        flit_hdr_t h;
        h.head = (k == 0);
        h.tail = (k == NF - 1);
        h.dest = d;
        return {h, w[k*FW +: FW]};
    endfunction

    // One clock: predict this edge from the model, let it happen, compare, then advance the model.
    task automatic tick();
        bit   acc, iss, stall;
        exp_t e;
        in_valid = (words_left > 0);
        case (credit_mode)
            1:       credit_in = (m_cnt < CR);
            2:       credit_in = (m_cnt < CR) && ($urandom_range(0, 1) == 1);
            3:       credit_in = (m_cnt < CR);
            default: credit_in = 1'b0;
        endcase
        #1;
        check("in_ready", in_ready, rst && (m_words < FD));
        acc   = rst && in_valid && (m_words < FD);
        iss   = rst && (m_cnt > 0) && (q.size() > 0) && (q[0].avail <= cyc);
        stall = rst && (m_words > 0) && (m_cnt == 0);
        @(posedge clk);
        #1;
        if (!rst) begin
            q.delete();
            m_words = 0; m_cnt = CR; m_last = '0; m_pkts = 0; m_stalls = 0;
            check("rst_flit_valid", flit_valid, 0);
            check("rst_flit_out", flit_out, 0);
        end else begin
            if (iss) begin
                e = q.pop_front();
                check("flit_valid", flit_valid, 1);
                check("flit_out", flit_out, e.f);
                m_last = e.f;
                n_iss++;
                if (e.f[TAIL_BIT]) begin
                    m_words--;
                    m_pkts++;
                end
            end else begin
                check("flit_idle", flit_valid, 0);
                check("flit_hold", flit_out, m_last);
            end
            if (iss && !credit_in)                      m_cnt--;
            else if (!iss && credit_in && m_cnt < CR)   m_cnt++;
            if (acc) begin
                for (int k = 0; k < NF; k++) q.push_back('{f: mk_flit(in_data, in_dest, k), avail: cyc + 1});
                m_words++;
                words_left--;
                in_data = rand_word();
                in_dest = DSW'($urandom);
            end
            if (stall) m_stalls++;
        end
        check("busy", busy, m_words > 0);
`ifdef NOC_PKTZ_STATS_EN
        check("pkt_count", pkt_count, m_pkts);
        check("stall_count", stall_count, m_stalls);
`endif
        cyc++;
    endtask

    task automatic drain();
        bit done = 0;
        words_left  = 0;
        credit_mode = 1;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            done = (q.size() == 0) && (m_cnt == CR);
        end
        check("drain_done", done, 1);
    endtask

    initial begin
        int  base;
        int  gaps;
        bit  hit;
        logic [FW-1:0] sa, sb, sc, sd;

        in_data = rand_word();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();

        // One word of four recognisable slices to node 5.
        sa = {10{15'h0A0A}}; sb = {10{15'h0B0B}}; sc = {10{15'h0C0C}}; sd = {10{15'h0D0D}};
        in_data = {sd, sc, sb, sa};
        in_dest = 4'd5;
        words_left = 1;
        base = n_iss;
        for (int i = 0; i < 7; i++) tick();
        check("t1_flits", n_iss - base, 4);
        check("t1_last_payload", flit_out[FW-1:0], sd);
        drain();

        // Three words with no credits returned: credit window stops the stream at 8 flits.
        credit_mode = 0;
        words_left  = 3;
        base = n_iss;
        for (int i = 0; i < 25; i++) tick();
        check("t2_stalled_flits", n_iss - base, CR);
        check("t2_stalled_valid", flit_valid, 0);
        check("t2_busy", busy, 1);
        credit_mode = 1;
        for (int i = 0; i < 20; i++) tick();
        check("t2_total_flits", n_iss - base, 3 * NF);
        drain();

        // Four back-to-back words with credits flowing: 16 flits with no idle cycle.
        credit_mode = 1;
        words_left  = 4;
        base = n_iss;
        gaps = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if ((n_iss - base) > 0 && (n_iss - base) < 4 * NF && !flit_valid) gaps++;
        end
        check("t3_flits", n_iss - base, 4 * NF);
        check("t3_gaps", gaps, 0);
        drain();

        // Credit returned in the cycle the last remaining credit is spent.
        credit_mode = 0;
        words_left  = 3;
        hit = 0;
        for (int i = 0; i < 60 && !hit; i++) begin
            if (m_cnt == 1 && q.size() > 0 && q[0].avail <= cyc) hit = 1;
            else tick();
        end
        check("t4_reached_cnt1", hit, 1);
        credit_mode = 3;
        tick();
        check("t4_issue_with_credit", flit_valid, 1);
        credit_mode = 0;
        tick();
        check("t4_next_issue", flit_valid, 1);
        tick();
        check("t4_then_stall", flit_valid, 0);
        drain();

        // Reset after the second flit of a packet.
        credit_mode = 1;
        words_left  = 1;
        base = n_iss;
        for (int i = 0; i < 20 && (n_iss - base) < 2; i++) tick();
        check("t5_two_flits", n_iss - base, 2);
        words_left = 0;
        rst = 1'b0;
        tick();
        check("t5_reset_valid", flit_valid, 0);
        tick();
        rst = 1'b1;
        credit_mode = 0;
        words_left  = 3;
        base = n_iss;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (n_iss - base == 1 && flit_valid) check("t5_first_is_head", flit_out[HEAD_BIT], 1);
        end
        check("t5_full_window", n_iss - base, CR);
        drain();

        // Random traffic with random credit return.
        credit_mode = 2;
        for (int i = 0; i < 400; i++) begin
            if (words_left == 0 && $urandom_range(0, 2) == 0) words_left = $urandom_range(1, 3);
            tick();
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
